// File: rtl/e_mdu.sv
// e_mdu - execute-stage multiply/divide unit.
//
// Holds the architectural HI/LO registers and models the multi-cycle latency
// of mult/multu/div/divu with a down-counter. The result is computed at issue
// and parked in a pending register; it lands in HI/LO on the edge where the
// counter reaches zero, so new values are visible in the first cycle with
// busy low.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   mdOp   in   [3:0] 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                     5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 none
//   A, B   in   [31:0] forwarded rs / rt operands
//   start  out  issue strobe: mult/div op presented while idle
//   busy   out  registered, high while a mult/div is in flight
//   out    out  [31:0] HI for mfhi, LO for mflo, else 0
//   HI, LO out  [31:0] architectural registers
module e_mdu #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mdOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic [31:0] out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW   = ($clog2(MAXC + 1) > 4) ? $clog2(MAXC + 1) : 4;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic [CW-1:0] cnt;
    logic          busy_r;
    logic [31:0]   hi_next;
    logic [31:0]   lo_next;
    logic          wr;

    logic          is_md;
    logic          is_mult;
    logic          is_sdiv;
    logic [63:0]   prod_u;
    logic [63:0]   prod_s;
    logic [31:0]   dvd;
    logic [31:0]   dvs;
    logic [31:0]   q_mag;
    logic [31:0]   r_mag;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;

    assign is_md   = (mdOp >= OP_MULT) && (mdOp <= OP_DIVU);
    assign is_mult = (mdOp == OP_MULT) || (mdOp == OP_MULTU);
    assign is_sdiv = (mdOp == OP_DIV);

    assign start = is_md && !busy_r;
    assign busy  = busy_r;

    // Low 64 bits of a sign-extended 64x64 product equal the signed 32x32 product.
    assign prod_u = {32'b0, A} * {32'b0, B};
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};

    // One unsigned divider serves both div and divu: signed division runs on
    // magnitudes and the signs are restored afterwards. A zero divisor is
    // replaced by 1 only to keep the arithmetic defined; that result is never
    // committed because wr stays low.
    assign dvd   = (is_sdiv && A[31]) ? (32'd0 - A) : A;
    assign dvs   = (B == 32'd0) ? 32'd1 : ((is_sdiv && B[31]) ? (32'd0 - B) : B);
    assign q_mag = dvd / dvs;
    assign r_mag = dvd % dvs;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (mdOp)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV: begin
                // Quotient truncates toward zero; remainder follows the dividend.
                // 0x80000000 / -1 wraps back to 0x80000000 with remainder 0.
                res_lo = (A[31] ^ B[31]) ? (32'd0 - q_mag) : q_mag;
                res_hi = A[31] ? (32'd0 - r_mag) : r_mag;
            end
            OP_DIVU: begin
                res_lo = q_mag;
                res_hi = r_mag;
            end
            default: ;
        endcase
    end

    always_comb begin
        out = 32'd0;
        case (mdOp)
            OP_MFHI: out = HI;
            OP_MFLO: out = LO;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            busy_r  <= 1'b0;
            hi_next <= 32'd0;
            lo_next <= 32'd0;
            wr      <= 1'b0;
            HI      <= 32'd0;
            LO      <= 32'd0;
        end else if (start) begin
            cnt     <= is_mult ? CW'(MULT_CYC) : CW'(DIV_CYC);
            busy_r  <= 1'b1;
            hi_next <= res_hi;
            lo_next <= res_lo;
            wr      <= is_mult || (B != 32'd0);
        end else if (busy_r) begin
            // Every op presented while busy is dropped; only the countdown runs.
            cnt    <= cnt - CW'(1);
            busy_r <= (cnt != CW'(1));
            if (cnt == CW'(1) && wr) begin
                HI <= hi_next;
                LO <= lo_next;
                wr <= 1'b0;
            end
        end else if (mdOp == OP_MTHI) begin
            HI <= A;
        end else if (mdOp == OP_MTLO) begin
            LO <= A;
        end
    end

endmodule
